// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between loads and a queued ALU path,
// with a pending-write scoreboard for decode hazards. Optional forwarding: define REGFILE_WB_FWD_EN.
`default_nettype none

module regfile_wb_arbiter #(
  parameter int ALU_Q_DEPTH = 2,
  parameter int STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_stall,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        rd_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err_unexp,
  output logic        fwd_rs,
  output logic        fwd_rt
);

  localparam int PW = $clog2(ALU_Q_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    q_rd_q   [ALU_Q_DEPTH];
  logic [31:0]   q_data_q [ALU_Q_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          err_q, err_d;

  logic          q_nonempty, q_full, starve_at_max;
  logic          push, pop, ld_grant, g_valid;
  logic [4:0]    g_rd;
  logic [31:0]   g_data;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign q_nonempty    = (wr_ptr_q != rd_ptr_q);
  assign q_full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign starve_at_max = (starve_q == SW'(STARVE_MAX));

  assign alu_ready = !q_full;
  assign ld_ready  = !(q_nonempty && starve_at_max);
  assign ld_grant  = ld_valid && ld_ready;
  assign pop       = !ld_grant && q_nonempty;
  assign push      = alu_valid && alu_ready;
  assign g_valid   = ld_grant || pop;
  assign g_rd      = ld_grant ? ld_rd   : q_rd_q[rd_ptr_q[PW-1:0]];
  assign g_data    = ld_grant ? ld_data : q_data_q[rd_ptr_q[PW-1:0]];

  assign iss_stall = iss_valid && pend_q[iss_rd];

`ifdef REGFILE_WB_FWD_EN
  logic hit_rs, hit_rt;
  assign hit_rs   = rf_we_q && (rs == rf_waddr_q);
  assign hit_rt   = rf_we_q && (rt == rf_waddr_q);
  assign rd_stall = (pend_q[rs] && !hit_rs) || (pend_q[rt] && !hit_rt);
  assign fwd_rs   = hit_rs && (rs != 5'd0);
  assign fwd_rt   = hit_rt && (rt != 5'd0);
`else
  assign rd_stall = pend_q[rs] || pend_q[rt];
  assign fwd_rs   = 1'b0;
  assign fwd_rt   = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);
    starve_d   = starve_q;
    pend_d     = pend_q;
    rf_we_d    = g_valid && (g_rd != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q || (g_valid && (g_rd != 5'd0) && !pend_q[g_rd]);

    if (!q_nonempty || pop) begin
      starve_d = '0;
    end else if (ld_grant && !starve_at_max) begin
      starve_d = starve_q + SW'(1);
    end

    if (g_valid) begin
      rf_waddr_d = g_rd;
      rf_wdata_d = g_data;
    end

    // A same-register set is impossible here: iss_stall blocks it while the bit is live.
    if (rf_we_q) begin
      pend_d[rf_waddr_q] = 1'b0;
    end
    if (iss_valid && !iss_stall && (iss_rd != 5'd0)) begin
      pend_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_q[wr_ptr_q[PW-1:0]]   <= alu_rd;
      q_data_q[wr_ptr_q[PW-1:0]] <= alu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      pend_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign err_unexp = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed literal checks plus randomized traffic compared every cycle
// against a queue-based behavioural model of the write-back arbiter.
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int ALU_Q_DEPTH = 2;
  localparam int STARVE_MAX  = 3;
`ifdef REGFILE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic [4:0]  rs, rt;
  logic        rd_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_unexp;
  logic        fwd_rs, fwd_rt;

  regfile_wb_arbiter #(.ALU_Q_DEPTH(ALU_Q_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .rs(rs), .rt(rt), .rd_stall(rd_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_unexp(err_unexp), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the ALU queue is a plain SV queue, the scoreboard a bit vector.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pend;
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_err;

  always @(negedge clk) begin
    bit ne, e_ld_ready, e_iss_stall, e_rd_stall, e_frs, e_frt, ps, pt;
    bit ld_g, pop, push, g;
    logic [4:0]  grd;
    logic [31:0] gd;
    logic [31:0] np;
    if (reset) begin
      mq.delete();
      m_pend = '0; m_starve = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
    end
    ne          = (mq.size() != 0);
    e_ld_ready  = !(ne && m_starve == STARVE_MAX);
    e_iss_stall = iss_valid && m_pend[iss_rd];
    ps = m_pend[rs];
    pt = m_pend[rt];
    e_frs = 0;
    e_frt = 0;
    if (FWD) begin
      if (m_we && rs == m_waddr) ps = 0;
      if (m_we && rt == m_waddr) pt = 0;
      e_frs = m_we && rs == m_waddr && rs != 0;
      e_frt = m_we && rt == m_waddr && rt != 0;
    end
    e_rd_stall = ps || pt;

    chk("iss_stall", {31'd0, iss_stall}, {31'd0, e_iss_stall});
    chk("rd_stall",  {31'd0, rd_stall},  {31'd0, e_rd_stall});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, mq.size() < ALU_Q_DEPTH});
    chk("ld_ready",  {31'd0, ld_ready},  {31'd0, e_ld_ready});
    chk("rf_we",     {31'd0, rf_we},     {31'd0, m_we});
    chk("err_unexp", {31'd0, err_unexp}, {31'd0, m_err});
    chk("fwd_rs",    {31'd0, fwd_rs},    {31'd0, e_frs});
    chk("fwd_rt",    {31'd0, fwd_rt},    {31'd0, e_frt});
    if (m_we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
      chk("rf_wdata", rf_wdata, m_wdata);
    end

    if (!reset) begin
      ld_g = ld_valid && e_ld_ready;
      pop  = !ld_g && ne;
      push = alu_valid && (mq.size() < ALU_Q_DEPTH);
      g    = ld_g || pop;
      grd  = 0;
      gd   = 0;
      if (ld_g) begin
        grd = ld_rd; gd = ld_data;
      end else if (pop) begin
        grd = mq[0].rd; gd = mq[0].d;
      end
      if (g && grd != 0 && !m_pend[grd]) m_err = 1;
      np = m_pend;
      if (m_we) np[m_waddr] = 0;
      if (iss_valid && !e_iss_stall && iss_rd != 0) np[iss_rd] = 1;
      m_pend = np;
      if (!ne || pop) m_starve = 0;
      else if (ld_g && m_starve < STARVE_MAX) m_starve++;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{rd: alu_rd, d: alu_data});
      m_we = g && grd != 0;
      if (g) begin
        m_waddr = grd; m_wdata = gd;
      end
    end
  end

  task automatic idle();
    iss_valid = 0; iss_rd = 0; rs = 0; rt = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    idle();
    iss_valid = 1; iss_rd = r;
    cyc();
  endtask

  initial begin
    reset = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // ALU path: push and issue rd=5 in the same cycle, write two cycles later.
    iss_valid = 1; iss_rd = 5; alu_valid = 1; alu_rd = 5; alu_data = 32'h52;
    @(negedge clk);
    chk("lit_reset_we", {31'd0, rf_we}, 32'd0);
    chk("lit_reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("lit_reset_wdata", rf_wdata, 32'd0);
    chk("lit_alu_ready", {31'd0, alu_ready}, 32'd1);
    cyc(); idle(); rs = 5;
    @(negedge clk);
    chk("lit_alu_n1_we", {31'd0, rf_we}, 32'd0);
    chk("lit_rd_stall5", {31'd0, rd_stall}, 32'd1);
    cyc();
    @(negedge clk);
    chk("lit_alu_n2_we", {31'd0, rf_we}, 32'd1);
    chk("lit_alu_n2_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("lit_alu_n2_wdata", rf_wdata, 32'h52);
    chk("lit_fwd_stall5", {31'd0, rd_stall}, FWD ? 32'd0 : 32'd1);
    chk("lit_fwd_rs5", {31'd0, fwd_rs}, FWD ? 32'd1 : 32'd0);
    cyc();
    @(negedge clk);
    chk("lit_pend5_clear", {31'd0, rd_stall}, 32'd0);

    // Load and ALU offered together: load first, ALU one cycle later.
    issue(3); issue(4); idle();
    ld_valid = 1; ld_rd = 3; ld_data = 32'h1A;
    alu_valid = 1; alu_rd = 4; alu_data = 32'hE9;
    cyc(); idle();
    @(negedge clk);
    chk("lit_ld_first_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("lit_ld_first_wdata", rf_wdata, 32'h1A);
    cyc();
    @(negedge clk);
    chk("lit_alu_second_we", {31'd0, rf_we}, 32'd1);
    chk("lit_alu_second_waddr", {27'd0, rf_waddr}, 32'd4);
    chk("lit_alu_second_wdata", rf_wdata, 32'hE9);
    cyc();

    // Starvation: three load wins, then the ALU head is forced through.
    for (int r = 10; r <= 14; r++) issue(5'(r));
    idle();
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
    cyc(); idle();
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1; ld_rd = 5'(11 + k); ld_data = 32'h100 + 32'(k);
      @(negedge clk);
      chk("lit_starve_ld_ready", {31'd0, ld_ready}, (k < 3) ? 32'd1 : 32'd0);
      if (k > 0) chk("lit_starve_ld_waddr", {27'd0, rf_waddr}, 32'(10 + k));
      cyc();
    end
    @(negedge clk);
    chk("lit_forced_alu_waddr", {27'd0, rf_waddr}, 32'd10);
    chk("lit_forced_alu_wdata", rf_wdata, 32'hA0);
    cyc(); idle();
    @(negedge clk);
    chk("lit_late_ld_wdata", rf_wdata, 32'h103);
    cyc();

    // RAW on rd=7 resolved by a load write.
    issue(7); idle(); rs = 7;
    @(negedge clk);
    chk("lit_raw7_stall", {31'd0, rd_stall}, 32'd1);
    cyc();
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    cyc(); idle(); rs = 7;
    @(negedge clk);
    chk("lit_raw7_write_stall", {31'd0, rd_stall}, FWD ? 32'd0 : 32'd1);
    chk("lit_raw7_fwd_rs", {31'd0, fwd_rs}, FWD ? 32'd1 : 32'd0);
    cyc();

    // r0 write is dropped; a write to a non-pending register raises the sticky error.
    idle(); ld_valid = 1; ld_rd = 0; ld_data = 32'hDEAD;
    cyc(); idle();
    @(negedge clk);
    chk("lit_r0_no_we", {31'd0, rf_we}, 32'd0);
    chk("lit_r0_no_err", {31'd0, err_unexp}, 32'd0);
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    cyc(); idle();
    @(negedge clk);
    chk("lit_unexp_waddr", {27'd0, rf_waddr}, 32'd9);
    chk("lit_unexp_err", {31'd0, err_unexp}, 32'd1);
    repeat (2) cyc();
    @(negedge clk);
    chk("lit_unexp_sticky", {31'd0, err_unexp}, 32'd1);

    // Reset while busy.
    cyc();
    issue(22); idle();
    alu_valid = 1; alu_rd = 20; alu_data = 32'h20; ld_valid = 1; ld_rd = 21;
    cyc();
    alu_rd = 23;
    reset = 1;
    rs = 22;
    @(negedge clk);
    chk("lit_rst_we", {31'd0, rf_we}, 32'd0);
    chk("lit_rst_err", {31'd0, err_unexp}, 32'd0);
    chk("lit_rst_pend", {31'd0, rd_stall}, 32'd0);
    cyc(); reset = 0; idle();
    @(negedge clk);
    chk("lit_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    cyc();

    // Randomized traffic; small register range keeps hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs        = 5'($urandom_range(0, 7));
      rt        = 5'($urandom_range(0, 7));
      alu_valid = ($urandom_range(0, 2) != 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 4) < 3);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      reset     = (i == 1500) || (i == 2400);
      cyc();
    end
    reset = 0;
    idle();
    repeat (6) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
